life_frame_scanner: RTL
=======================

# life_frame_scanner

Downstream consumer of the 10x10 Life grid. On a snapshot request it captures all 100 cell states in one cycle, then streams them out one 10-bit row at a time over a valid/ready interface to the display/UART side. It also reports a live-cell count and a frame counter. As a compile-time option, it flags still-life (frame identical to the previous one).

## Interface
Parameters:
- ROWS, 10, grid rows; fixed to 10 for the current grid.
- COLS, 10, grid columns; fixed to 10.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- cells  input  100  packed grid; bit i = state_i of the grid, row r = bits [r*10+9 : r*10].
- snap  input  1  capture request, sampled at the rising edge.
- row_data  output  10  current row; bit c = cell (r*10+c).
- row_idx  output  4  index of the row on row_data, 0..9.
- row_valid  output  1  row_data/row_idx valid.
- row_ready  input  1  consumer accepts the row.
- frame_last  output  1  high with row_valid while row_idx==9.
- busy  output  1  a frame is being streamed.
- snap_drop  output  1  1-cycle pulse: snap ignored because busy.
- pop_count  output  7  live-cell count of the last fully streamed frame, 0..100.
- frame_cnt  output  16  number of completed frames.
- stable  output  1  last captured frame equals the one before it (see Configuration).

## Operation
- The FSM has two states, IDLE and SEND.
- IDLE with snap=1:
  - Capture cells into the frame register.
  - Set row_idx=0 and enter SEND.
- SEND:
  - row_valid=1; row_data = frame[row_idx*10 +: 10].
  - A transfer occurs when row_valid && row_ready.
  - On a transfer, add popcount(row_data) to the accumulator and increment row_idx.
- Transfer of row 9:
  - pop_count <= accumulator + popcount(row 9).
  - The accumulator clears.
  - frame_cnt increments, wrapping 16'hFFFF -> 0.
  - Return to IDLE.
- Valid/ready rules:
  - While row_valid=1 and row_ready=0, row_data, row_idx and frame_last hold stable.
  - row_valid never drops without a transfer, except on reset.
- snap while in SEND, including the cycle of the row-9 transfer, is ignored and pulses snap_drop for one cycle. The frame register is untouched.
- cells changes after capture have no effect on the frame being streamed.
- Accumulator width is 7 bits; the maximum is 100, so there is no overflow.

## Timing
- Reset values (asynchronous, rst=0):
  - state=IDLE.
  - row_valid, busy, frame_last, snap_drop, stable = 0.
  - row_data=0, row_idx=0, pop_count=0, frame_cnt=0.
  - Frame, previous-frame and accumulator registers = 0.
- snap sampled at edge k gives row_valid=1 and busy=1 from edge k onward. Row 0 is visible in the cycle after edge k (latency 1).
- With row_ready held at 1, a frame takes 10 cycles. busy falls at the edge that transfers row 9.
- pop_count and frame_cnt update at that same edge.
- The earliest next accepted snap is the edge after busy falls. Maximum snapshot rate is 1 per 11 cycles.
- stable updates at the capture edge.
- Reset asserted mid-frame aborts immediately, with no partial count update. After rst releases, the block waits in IDLE for snap.

## Configuration
- STILL_DETECT_EN defined:
  - A 100-bit previous-frame register and a valid flag are kept.
  - At each capture, stable <= prev_valid && (cells == prev_frame).
  - Then prev_frame <= cells and prev_valid <= 1.
  - stable holds until the next capture.
- STILL_DETECT_EN undefined:
  - The previous-frame register and comparator are not built.
  - stable is tied to 0.

## Test plan
- Reset then idle: rst=0 for 2 cycles, release, no snap for 20 cycles -> row_valid=0, busy=0, frame_cnt=0, pop_count=0 throughout.
- Blinker frame, row_ready=1: cells with bits 44,45,46 set, snap one cycle.
  - Response: 10 transfers, row 4 = 10'b0001110000, all other rows = 0.
  - frame_last only on row_idx 9; pop_count=3 and frame_cnt=1 after the 10th transfer.
- Backpressure: same frame, row_ready=0 for cycles 3-6 of streaming -> row_data/row_idx frozen at row 2, no duplicates or skips, pop_count=3 at end.
- Overrun: snap while row_idx=5, then snap on the row-9 transfer cycle.
  - Response: snap_drop pulses twice, the frame completes unchanged, frame_cnt increments by 1 only.
- Still-life (STILL_DETECT_EN): block pattern (bits 11,12,21,22), snap twice with the frame done between.
  - Response: stable=0 after the 1st capture and 1 after the 2nd.
  - Changing to an all-zero grid and snapping again -> stable=0.
  - Without the macro, stable=0 always.
- Reset mid-frame: rst=0 at row_idx=6 -> all outputs to reset values within the same cycle (asynchronous). The next snap streams a fresh frame starting at row 0, and frame_cnt=1 after it.

Source files
------------

// File: rtl/life_frame_scanner.sv
// Captures a 10x10 Life grid on snap and streams it out row by row over valid/ready.
// Still-life detection is built only when STILL_DETECT_EN is defined; otherwise stable is tied low.
module life_frame_scanner #(
    parameter int ROWS = 10,
    parameter int COLS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS*COLS-1:0] cells,
    input  logic                 snap,
    output logic [COLS-1:0]      row_data,
    output logic [3:0]           row_idx,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 frame_last,
    output logic                 busy,
    output logic                 snap_drop,
    output logic [6:0]           pop_count,
    output logic [15:0]          frame_cnt,
    output logic                 stable
);

    localparam int N = ROWS * COLS;
    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q,      state_d;
    logic [N-1:0]    frame_q,      frame_d;
    logic [COLS-1:0] row_data_q,   row_data_d;
    logic [3:0]      row_idx_q,    row_idx_d;
    logic            frame_last_q, frame_last_d;
    logic            snap_drop_q,  snap_drop_d;
    logic [6:0]      acc_q,        acc_d;
    logic [6:0]      pop_count_q,  pop_count_d;
    logic [15:0]     frame_cnt_q,  frame_cnt_d;

    logic [3:0]      next_idx;
    logic [6:0]      row_pop;
    logic            capture;

    function automatic logic [6:0] popcount(input logic [COLS-1:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int i = 0; i < COLS; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [COLS-1:0] row_of(input logic [N-1:0] f, input logic [3:0] idx);
        return f[idx*COLS +: COLS];
    endfunction

    assign next_idx = row_idx_q + 4'd1;
    assign row_pop  = popcount(row_data_q);
    assign capture  = (state_q == IDLE) && snap;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        row_data_d   = row_data_q;
        row_idx_d    = row_idx_q;
        frame_last_d = frame_last_q;
        snap_drop_d  = 1'b0;
        acc_d        = acc_q;
        pop_count_d  = pop_count_q;
        frame_cnt_d  = frame_cnt_q;
        case (state_q)
            IDLE: begin
                if (snap) begin
                    frame_d      = cells;
                    row_data_d   = cells[COLS-1:0];
                    row_idx_d    = 4'd0;
                    frame_last_d = (LAST_ROW == 4'd0);
                    acc_d        = '0;
                    state_d      = SEND;
                end
            end
            SEND: begin
                snap_drop_d = snap;
                if (row_ready) begin
                    if (row_idx_q == LAST_ROW) begin
                        // Final transfer: publish the frame's statistics and go idle.
                        pop_count_d  = acc_q + row_pop;
                        acc_d        = '0;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        frame_last_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        acc_d        = acc_q + row_pop;
                        row_idx_d    = next_idx;
                        row_data_d   = row_of(frame_q, next_idx);
                        frame_last_d = (next_idx == LAST_ROW);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            row_data_q   <= '0;
            row_idx_q    <= '0;
            frame_last_q <= 1'b0;
            snap_drop_q  <= 1'b0;
            acc_q        <= '0;
            pop_count_q  <= '0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            row_data_q   <= row_data_d;
            row_idx_q    <= row_idx_d;
            frame_last_q <= frame_last_d;
            snap_drop_q  <= snap_drop_d;
            acc_q        <= acc_d;
            pop_count_q  <= pop_count_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

`ifdef STILL_DETECT_EN
    logic [N-1:0] prev_frame_q, prev_frame_d;
    logic         prev_valid_q, prev_valid_d;
    logic         stable_q,     stable_d;

    // Compare against the raw input at capture so stable is ready with row 0.
    always_comb begin
        prev_frame_d = prev_frame_q;
        prev_valid_d = prev_valid_q;
        stable_d     = stable_q;
        if (capture) begin
            stable_d     = prev_valid_q && (cells == prev_frame_q);
            prev_frame_d = cells;
            prev_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_frame_q <= '0;
            prev_valid_q <= 1'b0;
            stable_q     <= 1'b0;
        end else begin
            prev_frame_q <= prev_frame_d;
            prev_valid_q <= prev_valid_d;
            stable_q     <= stable_d;
        end
    end

    assign stable = stable_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign stable         = 1'b0;
`endif

    assign row_data   = row_data_q;
    assign row_idx    = row_idx_q;
    assign row_valid  = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign frame_last = frame_last_q;
    assign snap_drop  = snap_drop_q;
    assign pop_count  = pop_count_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
